itch_order_msg_decoder: RTL and testbench
=========================================

Name: itch_order_msg_decoder

Overview:
- Speculative byte-serial decoder for NASDAQ ITCH 5.0 Add Order ('A') and Order Cancel ('X') messages.
- Sits directly behind the byte-stream front end; one input byte per clock, qualified by valid_in.
- Contains two parallel sub-decoders that watch the same stream: one for Add Order, one for Cancel.
- Each sub-decoder emits a one-cycle valid pulse with extracted fields, or a one-cycle invalid pulse for a truncated message.

Parameters:
- None. Message lengths (Add = 36 bytes, Cancel = 23 bytes) and type codes (0x41, 0x58) are fixed internal constants.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- byte_in  input  8  stream byte.
- valid_in  input  1  byte_in is valid this cycle.
- add_internal_valid  output  1  one-cycle pulse: complete Add Order decoded.
- add_packet_invalid  output  1  one-cycle pulse: Add Order truncated.
- add_order_ref  output  64  order reference number, bytes 11–18.
- add_side  output  1  buy/sell indicator from byte 19: 0 = 'B' (0x42), 1 = 'S' (0x53).
- add_shares  output  32  share count, bytes 20–23.
- add_stock_symbol  output  64  stock symbol, bytes 24–31; byte 24 is in bits [63:56].
- add_price  output  32  price, bytes 32–35.
- cancel_internal_valid  output  1  one-cycle pulse: complete Cancel decoded.
- cancel_packet_invalid  output  1  one-cycle pulse: Cancel truncated.
- cancel_order_ref  output  64  order reference number, bytes 11–18.
- cancel_canceled_shares  output  32  cancelled share count, bytes 19–22.

Behaviour:
- Reset (synchronous, active-high): every output is 0, byte counters are 0, and both sub-decoders go to IDLE. Reset mid-message discards the partial message with no pulse.
- Framing: a message is a contiguous run of valid_in = 1 cycles. Byte 0 is the type byte.
- Each sub-decoder keeps its own byte counter and state machine.
- States:
  - IDLE: waiting for a type byte.
  - CAPTURE: own type matched; capturing payload bytes.
  - SKIP: foreign type; waiting for valid_in = 0.
- Transitions:
  - IDLE with valid_in = 1: go to CAPTURE if byte_in equals own type (0x41 for Add, 0x58 for Cancel); otherwise go to SKIP.
  - SKIP: return to IDLE on the first cycle with valid_in = 0.
  - CAPTURE: each valid byte increments the counter and is written into the field register for its offset.
  - Bytes 1–10 (stock locate, tracking number, timestamp) are consumed and discarded.
- Byte order: all multi-byte fields are big-endian. The first received byte lands in the field's MSB.
- Field capture is speculative: field registers update as bytes arrive, so partial values are visible before the valid pulse. Only values qualified by *_internal_valid are meaningful.
- Completion: the cycle after the last byte is sampled (byte 35 for Add, byte 22 for Cancel), *_internal_valid is 1 for exactly one cycle. Latency is 1 clock from the last byte. All fields are stable during that cycle and hold until overwritten by a later message.
- Back-to-back: after the last byte, the sub-decoder returns to IDLE in the same cycle. If valid_in stays high, the next byte is treated as a new type byte with no idle gap required.
- Truncation: valid_in = 0 while in CAPTURE before the final byte gives *_packet_invalid = 1 for one cycle on the following cycle. The sub-decoder then returns to IDLE and *_internal_valid is not asserted.
- Invalid side (Add only): a side byte other than 'B' or 'S' marks the message bad. On completion, add_packet_invalid pulses instead of add_internal_valid.
- Mutual exclusion: *_internal_valid and *_packet_invalid of the same decoder are never 1 in the same cycle.
- Independence: Add and Cancel sub-decoders never interfere. For any given message, at most one decoder is in CAPTURE.
- valid_in = 0 in IDLE or SKIP has no effect on outputs other than the SKIP-to-IDLE transition.

Test Plan:
- Reset: hold rst for 2 cycles → all outputs 0; stream of 0x00 bytes with valid_in = 0 → no pulses.
- Add Order: 36-byte 'A' message, order ref 0x0000000000ABCDEF, side 'S', shares 100, stock "AAPL    " (0x4141504C20202020), price 1500000 → add_internal_valid pulses once, 1 cycle after byte 35. Fields: add_side = 1, add_shares = 0x64, add_price = 0x0016E360, cancel pulses = 0.
- Cancel: 23-byte 'X' message, order ref 0x1122334455667788, cancelled shares 50 → cancel_internal_valid pulses once, 1 cycle after byte 22. cancel_canceled_shares = 0x32; no add pulses.
- Back-to-back: 'A' message immediately followed by 'X' message, valid_in held high for 59 cycles → add pulse after byte 35, cancel pulse 23 cycles later, both field sets correct.
- Truncation: 'A' message with valid_in dropped after byte 20 → add_packet_invalid pulses once, add_internal_valid stays 0. A following full 'X' message still decodes correctly.
- Foreign type / reset mid-message: 'E' (0x45) message of 31 bytes → no pulses. rst asserted at byte 15 of an 'A' message → no pulse, outputs 0, and the next full 'A' message decodes correctly.

Source files
------------

// File: rtl/itch_order_msg_decoder_if.sv
// Stream input and decoded-field outputs of the ITCH Add Order / Order Cancel decoder.
// The master drives the byte stream. The slave is the decoder, which drives the results.
interface itch_order_msg_decoder_if;
    logic [7:0]  byte_in;
    logic        valid_in;

    logic        add_internal_valid;
    logic        add_packet_invalid;
    logic [63:0] add_order_ref;
    logic        add_side;
    logic [31:0] add_shares;
    logic [63:0] add_stock_symbol;
    logic [31:0] add_price;

    logic        cancel_internal_valid;
    logic        cancel_packet_invalid;
    logic [63:0] cancel_order_ref;
    logic [31:0] cancel_canceled_shares;

    modport master (
        output byte_in, valid_in,
        input  add_internal_valid, add_packet_invalid, add_order_ref, add_side,
               add_shares, add_stock_symbol, add_price,
               cancel_internal_valid, cancel_packet_invalid, cancel_order_ref,
               cancel_canceled_shares
    );

    modport slave (
        input  byte_in, valid_in,
        output add_internal_valid, add_packet_invalid, add_order_ref, add_side,
               add_shares, add_stock_symbol, add_price,
               cancel_internal_valid, cancel_packet_invalid, cancel_order_ref,
               cancel_canceled_shares
    );
endinterface

// File: rtl/itch_order_msg_decoder.sv
// Speculative byte-serial decoder for ITCH 5.0 Add Order ('A') and Order Cancel ('X').
// Two independent framers watch the same stream, and each one captures its own message type.
module itch_order_msg_decoder (
    input  logic                     clk,
    input  logic                     rst,
    itch_order_msg_decoder_if.slave  msg
);
    localparam logic [7:0] ADD_TYPE    = 8'h41;
    localparam logic [7:0] CANCEL_TYPE = 8'h58;
    localparam logic [7:0] SIDE_BUY    = 8'h42;
    localparam logic [7:0] SIDE_SELL   = 8'h53;

    // Byte offsets of the final byte of each message and of each big-endian field.
    localparam logic [5:0] ADD_LAST    = 6'd35;
    localparam logic [5:0] CANCEL_LAST = 6'd22;
    localparam logic [5:0] REF_LAST    = 6'd18;
    localparam logic [5:0] SIDE_OFS    = 6'd19;
    localparam logic [5:0] SHARES_LAST = 6'd23;
    localparam logic [5:0] STOCK_LAST  = 6'd31;

    typedef enum logic [1:0] {IDLE, CAPTURE, SKIP} state_t;

    typedef struct packed {
        state_t     state;
        logic [5:0] cnt;         // offset of the byte expected next
        logic       skip_known;  // skipped message is the peer type, so its length is known
    } frame_t;

    typedef struct packed {
        frame_t frame;
        logic   capture;
        logic   done;
        logic   truncate;
    } step_t;

    // Next-state function shared by both framers. A skipped peer-type message is counted out
    // so that a back-to-back message that follows it is recognised without an idle gap.
    function automatic step_t frame_step(
        input frame_t     cur,
        input logic       valid,
        input logic [7:0] data,
        input logic [7:0] own_type,
        input logic [5:0] own_last,
        input logic [7:0] peer_type,
        input logic [5:0] peer_last
    );
        step_t s;
        // NOTE: every field gets a default first, so no path through the case leaves a latch.
        s       = '0;
        s.frame = cur;
        case (cur.state)
            IDLE: begin
                if (valid) begin
                    s.frame.cnt = 6'd1;
                    if (data == own_type) begin
                        s.frame.state      = CAPTURE;
                        s.frame.skip_known = 1'b0;
                    end else begin
                        s.frame.state      = SKIP;
                        s.frame.skip_known = (data == peer_type);
                    end
                end
            end
            CAPTURE: begin
                if (valid) begin
                    s.capture = 1'b1;
                    if (cur.cnt == own_last) begin
                        s.done  = 1'b1;
                        s.frame = '0;
                    end else begin
                        s.frame.cnt = cur.cnt + 6'd1;
                    end
                end else begin
                    s.truncate = 1'b1;
                    s.frame    = '0;
                end
            end
            SKIP: begin
                if (!valid || (cur.skip_known && cur.cnt == peer_last)) begin
                    s.frame = '0;
                end else begin
                    s.frame.cnt = cur.cnt + 6'd1;
                end
            end
            default: s.frame = '0;
        endcase
        return s;
    endfunction

    // Bit position of the current byte inside a big-endian field that ends at offset 'last'.
    function automatic logic [5:0] lane64(input logic [5:0] last, input logic [5:0] cnt);
        return {3'(last - cnt), 3'b000};
    endfunction

    function automatic logic [4:0] lane32(input logic [5:0] last, input logic [5:0] cnt);
        return {2'(last - cnt), 3'b000};
    endfunction

    frame_t add_frame_q;
    frame_t cancel_frame_q;
    step_t  add_step;
    step_t  cancel_step;

    always_comb begin
        add_step    = frame_step(add_frame_q, msg.valid_in, msg.byte_in,
                                 ADD_TYPE, ADD_LAST, CANCEL_TYPE, CANCEL_LAST);
        cancel_step = frame_step(cancel_frame_q, msg.valid_in, msg.byte_in,
                                 CANCEL_TYPE, CANCEL_LAST, ADD_TYPE, ADD_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments, so both framers see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_frame_q    <= '0;
            cancel_frame_q <= '0;
        end else begin
            add_frame_q    <= add_step.frame;
            cancel_frame_q <= cancel_step.frame;
        end
    end

    logic        add_internal_valid;
    logic        add_packet_invalid;
    logic        add_bad_side;
    logic [63:0] add_order_ref;
    logic        add_side;
    logic [31:0] add_shares;
    logic [63:0] add_stock_symbol;
    logic [31:0] add_price;
    logic        cancel_internal_valid;
    logic        cancel_packet_invalid;
    logic [63:0] cancel_order_ref;
    logic [31:0] cancel_canceled_shares;

    // NOTE: the field registers are reset on purpose, because every visible output must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_internal_valid     <= 1'b0;
            add_packet_invalid     <= 1'b0;
            add_bad_side           <= 1'b0;
            add_order_ref          <= '0;
            add_side               <= 1'b0;
            add_shares             <= '0;
            add_stock_symbol       <= '0;
            add_price              <= '0;
            cancel_internal_valid  <= 1'b0;
            cancel_packet_invalid  <= 1'b0;
            cancel_order_ref       <= '0;
            cancel_canceled_shares <= '0;
        end else begin
            // The side byte arrives long before the last byte, so add_bad_side is settled at completion.
            add_internal_valid    <= add_step.done && !add_bad_side;
            add_packet_invalid    <= add_step.truncate || (add_step.done && add_bad_side);
            cancel_internal_valid <= cancel_step.done;
            cancel_packet_invalid <= cancel_step.truncate;

            if (add_step.done || add_step.truncate) begin
                add_bad_side <= 1'b0;
            end

            if (add_step.capture) begin
                case (add_frame_q.cnt) inside
                    [6'd11:6'd18]:
                        add_order_ref[lane64(REF_LAST, add_frame_q.cnt) +: 8] <= msg.byte_in;
                    SIDE_OFS: begin
                        add_side     <= (msg.byte_in == SIDE_SELL);
                        add_bad_side <= (msg.byte_in != SIDE_BUY) && (msg.byte_in != SIDE_SELL);
                    end
                    [6'd20:6'd23]:
                        add_shares[lane32(SHARES_LAST, add_frame_q.cnt) +: 8] <= msg.byte_in;
                    [6'd24:6'd31]:
                        add_stock_symbol[lane64(STOCK_LAST, add_frame_q.cnt) +: 8] <= msg.byte_in;
                    [6'd32:6'd35]:
                        add_price[lane32(ADD_LAST, add_frame_q.cnt) +: 8] <= msg.byte_in;
                    default: ;
                endcase
            end

            if (cancel_step.capture) begin
                case (cancel_frame_q.cnt) inside
                    [6'd11:6'd18]:
                        cancel_order_ref[lane64(REF_LAST, cancel_frame_q.cnt) +: 8] <= msg.byte_in;
                    [6'd19:6'd22]:
                        cancel_canceled_shares[lane32(CANCEL_LAST, cancel_frame_q.cnt) +: 8] <= msg.byte_in;
                    default: ;
                endcase
            end
        end
    end

    assign msg.add_internal_valid     = add_internal_valid;
    assign msg.add_packet_invalid     = add_packet_invalid;
    assign msg.add_order_ref          = add_order_ref;
    assign msg.add_side               = add_side;
    assign msg.add_shares             = add_shares;
    assign msg.add_stock_symbol       = add_stock_symbol;
    assign msg.add_price              = add_price;
    assign msg.cancel_internal_valid  = cancel_internal_valid;
    assign msg.cancel_packet_invalid  = cancel_packet_invalid;
    assign msg.cancel_order_ref       = cancel_order_ref;
    assign msg.cancel_canceled_shares = cancel_canceled_shares;
endmodule

// File: tb/tb_itch_order_msg_decoder.sv
// Bench for itch_order_msg_decoder. It runs directed and random byte streams.
// Expected pulses and fields come from a message-level parse of the stream.
module tb_itch_order_msg_decoder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    itch_order_msg_decoder_if bus ();

    itch_order_msg_decoder dut (
        .clk (clk),
        .rst (rst),
        .msg (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    logic [7:0] s_byte[$];
    bit         s_valid[$];

    task automatic push(input logic [7:0] b, input bit v);
        s_byte.push_back(b);
        s_valid.push_back(v);
    endtask

    task automatic push_idle(input int n);
        repeat (n) push(8'h00, 1'b0);
    endtask

    task automatic push_add(input logic [63:0] oref, input logic [7:0] side, input logic [31:0] shares,
                            input logic [63:0] stock, input logic [31:0] price, input int nbytes);
        logic [7:0] m[36];
        m[0] = 8'h41;
        for (int k = 1; k <= 10; k++) m[k] = 8'($urandom);
        for (int k = 0; k < 8; k++) m[11 + k] = oref[63 - 8 * k -: 8];
        m[19] = side;
        for (int k = 0; k < 4; k++) m[20 + k] = shares[31 - 8 * k -: 8];
        for (int k = 0; k < 8; k++) m[24 + k] = stock[63 - 8 * k -: 8];
        for (int k = 0; k < 4; k++) m[32 + k] = price[31 - 8 * k -: 8];
        for (int k = 0; k < nbytes; k++) push(m[k], 1'b1);
    endtask

    task automatic push_cancel(input logic [63:0] oref, input logic [31:0] shares, input int nbytes);
        logic [7:0] m[23];
        m[0] = 8'h58;
        for (int k = 1; k <= 10; k++) m[k] = 8'($urandom);
        for (int k = 0; k < 8; k++) m[11 + k] = oref[63 - 8 * k -: 8];
        for (int k = 0; k < 4; k++) m[19 + k] = shares[31 - 8 * k -: 8];
        for (int k = 0; k < nbytes; k++) push(m[k], 1'b1);
    endtask

    task automatic push_foreign(input logic [7:0] t, input int nbytes);
        push(t, 1'b1);
        for (int k = 1; k < nbytes; k++) push(8'($urandom), 1'b1);
    endtask

    // Big-endian value of 'len' stream bytes starting at 'start'.
    function automatic logic [63:0] be(input int start, input int len);
        logic [63:0] v = '0;
        for (int k = 0; k < len; k++) v = (v << 8) | 64'(s_byte[start + k]);
        return v;
    endfunction

    typedef struct packed {
        logic        av, ai, cv, ci;
        logic [63:0] aref;
        logic        aside;
        logic [31:0] ashares;
        logic [63:0] astock;
        logic [31:0] aprice;
        logic [63:0] cref;
        logic [31:0] cshares;
    } exp_t;

    // The model splits the stream into runs of valid bytes and parses each run message by message.
    // Pulses are indexed by the cycle whose byte (or whose dropped valid) caused them.
    task automatic run_stream();
        int   n;
        int   i;
        int   run_end;
        int   last;
        exp_t e[];
        n = s_byte.size();
        e = new[n];
        for (int k = 0; k < n; k++) e[k] = '0;
        i = 0;
        while (i < n) begin
            if (!s_valid[i]) begin
                i++;
                continue;
            end
            run_end = i;
            while (run_end < n && s_valid[run_end]) run_end++;
            if (s_byte[i] == 8'h41) begin
                if (run_end - i >= 36) begin
                    last = i + 35;
                    if (s_byte[i + 19] == 8'h42 || s_byte[i + 19] == 8'h53) begin
                        e[last].av      = 1'b1;
                        e[last].aref    = be(i + 11, 8);
                        e[last].aside   = (s_byte[i + 19] == 8'h53);
                        e[last].ashares = 32'(be(i + 20, 4));
                        e[last].astock  = be(i + 24, 8);
                        e[last].aprice  = 32'(be(i + 32, 4));
                    end else begin
                        e[last].ai = 1'b1;
                    end
                    i += 36;
                end else begin
                    if (run_end < n) e[run_end].ai = 1'b1;
                    i = run_end;
                end
            end else if (s_byte[i] == 8'h58) begin
                if (run_end - i >= 23) begin
                    last = i + 22;
                    e[last].cv      = 1'b1;
                    e[last].cref    = be(i + 11, 8);
                    e[last].cshares = 32'(be(i + 19, 4));
                    i += 23;
                end else begin
                    if (run_end < n) e[run_end].ci = 1'b1;
                    i = run_end;
                end
            end else begin
                i = run_end;
            end
        end

        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.valid_in = s_valid[k];
            bus.byte_in  = s_byte[k];
            @(posedge clk);
            #1;
            check($sformatf("add_valid@%0d", k), 64'(bus.add_internal_valid), 64'(e[k].av));
            check($sformatf("add_invalid@%0d", k), 64'(bus.add_packet_invalid), 64'(e[k].ai));
            check($sformatf("cancel_valid@%0d", k), 64'(bus.cancel_internal_valid), 64'(e[k].cv));
            check($sformatf("cancel_invalid@%0d", k), 64'(bus.cancel_packet_invalid), 64'(e[k].ci));
            if (e[k].av) begin
                check($sformatf("add_order_ref@%0d", k), bus.add_order_ref, e[k].aref);
                check($sformatf("add_side@%0d", k), 64'(bus.add_side), 64'(e[k].aside));
                check($sformatf("add_shares@%0d", k), 64'(bus.add_shares), 64'(e[k].ashares));
                check($sformatf("add_stock@%0d", k), bus.add_stock_symbol, e[k].astock);
                check($sformatf("add_price@%0d", k), 64'(bus.add_price), 64'(e[k].aprice));
            end
            if (e[k].cv) begin
                check($sformatf("cancel_order_ref@%0d", k), bus.cancel_order_ref, e[k].cref);
                check($sformatf("cancel_shares@%0d", k), 64'(bus.cancel_canceled_shares), 64'(e[k].cshares));
            end
        end
        s_byte.delete();
        s_valid.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_add_valid"}, 64'(bus.add_internal_valid), 64'd0);
        check({tag, "_add_invalid"}, 64'(bus.add_packet_invalid), 64'd0);
        check({tag, "_add_ref"}, bus.add_order_ref, 64'd0);
        check({tag, "_add_side"}, 64'(bus.add_side), 64'd0);
        check({tag, "_add_shares"}, 64'(bus.add_shares), 64'd0);
        check({tag, "_add_stock"}, bus.add_stock_symbol, 64'd0);
        check({tag, "_add_price"}, 64'(bus.add_price), 64'd0);
        check({tag, "_cancel_valid"}, 64'(bus.cancel_internal_valid), 64'd0);
        check({tag, "_cancel_invalid"}, 64'(bus.cancel_packet_invalid), 64'd0);
        check({tag, "_cancel_ref"}, bus.cancel_order_ref, 64'd0);
        check({tag, "_cancel_shares"}, 64'(bus.cancel_canceled_shares), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         kind;
        int         gap;
        logic [7:0] t;
        logic [7:0] side;

        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.byte_in  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle bytes of 0x00 must produce no pulses.
        push_idle(8);
        run_stream();

        // Directed Add Order.
        push_add(64'h0000_0000_00AB_CDEF, 8'h53, 32'd100, 64'h4141_504C_2020_2020, 32'd1500000, 36);
        push_idle(3);
        run_stream();
        check("dir_add_side", 64'(bus.add_side), 64'd1);
        check("dir_add_shares", 64'(bus.add_shares), 64'h64);
        check("dir_add_price", 64'(bus.add_price), 64'h0016_E360);
        check("dir_add_stock", bus.add_stock_symbol, 64'h4141_504C_2020_2020);

        // Directed Cancel.
        push_cancel(64'h1122_3344_5566_7788, 32'd50, 23);
        push_idle(3);
        run_stream();
        check("dir_cancel_ref", bus.cancel_order_ref, 64'h1122_3344_5566_7788);
        check("dir_cancel_shares", 64'(bus.cancel_canceled_shares), 64'h32);

        // Back-to-back Add then Cancel with valid_in held high for 59 cycles.
        push_add(64'hDEAD_BEEF_0102_0304, 8'h42, 32'd777, 64'h4D53_4654_2020_2020, 32'd123456, 36);
        push_cancel(64'h0A0B_0C0D_0E0F_1011, 32'd9, 23);
        push_idle(3);
        run_stream();

        // Add truncated after byte 20, then a full Cancel.
        push_add(64'h1, 8'h53, 32'd5, 64'h2, 32'd3, 21);
        push_idle(2);
        push_cancel(64'h5555_AAAA_5555_AAAA, 32'd1234, 23);
        push_idle(3);
        run_stream();

        // Foreign type 'E', 31 bytes.
        push_foreign(8'h45, 31);
        push_idle(3);
        run_stream();

        // Reset asserted at byte 15 of an Add message.
        push_add(64'hFFFF_0000_FFFF_0000, 8'h42, 32'd1, 64'h3, 32'd4, 16);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 15) rst = 1'b1;
            bus.valid_in = s_valid[k];
            bus.byte_in  = s_byte[k];
            @(posedge clk);
            #1;
            if (k < 15) begin
                check($sformatf("pre_reset_add_valid@%0d", k), 64'(bus.add_internal_valid), 64'd0);
                check($sformatf("pre_reset_add_invalid@%0d", k), 64'(bus.add_packet_invalid), 64'd0);
            end
        end
        s_byte.delete();
        s_valid.delete();
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.byte_in  = 8'h00;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        push_add(64'h0123_4567_89AB_CDEF, 8'h53, 32'd42, 64'h5453_4C41_2020_2020, 32'd999, 36);
        push_idle(3);
        run_stream();

        // Random mix of complete, truncated, bad-side and foreign messages.
        for (int m = 0; m < 60; m++) begin
            kind = $urandom_range(0, 6);
            gap  = $urandom_range(0, 2);
            case (kind)
                0, 1: begin
                    side = ($urandom_range(0, 1) == 1) ? 8'h53 : 8'h42;
                    push_add({$urandom, $urandom}, side, $urandom, {$urandom, $urandom}, $urandom, 36);
                end
                2: push_cancel({$urandom, $urandom}, $urandom, 23);
                3: begin
                    push_add({$urandom, $urandom}, 8'h42, $urandom, {$urandom, $urandom}, $urandom,
                             $urandom_range(1, 35));
                    gap = $urandom_range(1, 2);
                end
                4: begin
                    push_cancel({$urandom, $urandom}, $urandom, $urandom_range(1, 22));
                    gap = $urandom_range(1, 2);
                end
                5: begin
                    side = 8'($urandom);
                    if (side == 8'h42 || side == 8'h53) side = 8'h00;
                    push_add({$urandom, $urandom}, side, $urandom, {$urandom, $urandom}, $urandom, 36);
                end
                default: begin
                    t = 8'($urandom);
                    if (t == 8'h41 || t == 8'h58) t = 8'h45;
                    push_foreign(t, $urandom_range(1, 40));
                    gap = $urandom_range(1, 2);
                end
            endcase
            push_idle(gap);
        end
        push_idle(3);
        run_stream();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
